// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell (two half adders + carry flop) walks WIDTH-bit operands LSB first.
// Result and done arrive WIDTH+1 edges after accept; start is ignored outside IDLE (no queueing).
module half_add (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s1;
    logic             w_c1;
    logic             w_s;
    logic             w_c2;
    logic             w_c;
    logic [WIDTH-1:0] w_sum_nxt;

    half_add u_ha0 (.i_x(r_a_sh[0]), .i_y(r_b_sh[0]), .o_s(w_s1), .o_c(w_c1));
    half_add u_ha1 (.i_x(w_s1),      .i_y(r_carry),   .o_s(w_s),  .o_c(w_c2));
    assign w_c = w_c1 | w_c2;

    // Only the upper WIDTH-1 partial-sum bits need storage; the new bit enters at the MSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_nxt = w_s;
        end else begin : g_wn
            logic [WIDTH-2:0] r_sum_hi;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sum_hi <= '0;
                end else if (r_state == S_IDLE && i_start) begin
                    r_sum_hi <= '0;
                end else if (r_state == S_RUN) begin
                    r_sum_hi <= w_sum_nxt[WIDTH-1:1];
                end
            end
            assign w_sum_nxt = {w_s, r_sum_hi};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a_sh  <= i_a;
                        r_b_sh  <= i_b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_sum_nxt;
                        r_cout  <= w_c;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;
    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_vec = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a8), .i_b(b8),
        .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_a(a1), .i_b(b1),
        .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [1:0] w1_a [4];
    logic [1:0] w1_b [4];
    logic [1:0] w1_s [4];
    logic [1:0] w1_c [4];
    int gap;

    initial begin
        w1_a = '{2'd0, 2'd0, 2'd1, 2'd1};
        w1_b = '{2'd0, 2'd1, 2'd0, 2'd1};
        w1_s = '{2'd0, 2'd1, 2'd1, 2'd0};
        w1_c = '{2'd0, 2'd0, 2'd0, 2'd1};

        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        ticks(2);
        rst = 1'b0;

        // Reset state, stable for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_busy", 32'(busy8), 32'd0);
            chk("rst_done", 32'(done8), 32'd0);
            chk("rst_sum",  32'(sum8),  32'h00);
            chk("rst_cout", 32'(cout8), 32'd0);
        end
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);

        // Full carry ripple: FF + 01
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ripple_busy", 32'(busy8), 32'd1);
            chk("ripple_nodone", 32'(done8), 32'd0);
            chk("ripple_sum_hold", 32'(sum8), 32'h00);
            tick();
        end
        chk("ripple_done", 32'(done8), 32'd1);
        chk("ripple_busy_lo", 32'(busy8), 32'd0);
        chk("ripple_sum", 32'(sum8), 32'h00);
        chk("ripple_cout", 32'(cout8), 32'd1);
        tick();
        chk("ripple_done_pulse", 32'(done8), 32'd0);
        chk("ripple_sum_keep", 32'(cout8), 32'd1);

        // No-carry add, with a start pulse during RUN that must be ignored
        a8 = 8'hA5; b8 = 8'h5A; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ticks(2);
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("a5_sum_hold", 32'(sum8), 32'h00);
        chk("a5_cout_hold", 32'(cout8), 32'd1);
        ticks(5);
        chk("a5_done", 32'(done8), 32'd1);
        chk("a5_sum", 32'(sum8), 32'hFF);
        chk("a5_cout", 32'(cout8), 32'd0);
        ticks(2);
        chk("a5_no_queue_busy", 32'(busy8), 32'd0);
        chk("a5_no_queue_done", 32'(done8), 32'd0);
        chk("a5_sum_keep", 32'(sum8), 32'hFF);

        // Reset mid-operation on the 4th RUN cycle
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ticks(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_done", 32'(done8), 32'd0);
        chk("midrst_sum",  32'(sum8),  32'h00);
        chk("midrst_cout", 32'(cout8), 32'd0);
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ticks(8);
        chk("after_rst_done", 32'(done8), 32'd1);
        chk("after_rst_sum",  32'(sum8),  32'h00);
        chk("after_rst_cout", 32'(cout8), 32'd1);
        tick();

        // Back-to-back with start held high; operands change during first RUN
        a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
        tick();
        a8 = 8'h10; b8 = 8'h20;
        ticks(8);
        chk("b2b1_done", 32'(done8), 32'd1);
        chk("b2b1_sum",  32'(sum8),  32'h08);
        chk("b2b1_cout", 32'(cout8), 32'd0);
        tick();
        chk("b2b_idle_busy", 32'(busy8), 32'd0);
        tick();
        chk("b2b_accept_busy", 32'(busy8), 32'd1);
        chk("b2b_sum_hold", 32'(sum8), 32'h08);
        gap = 2;
        while (done8 !== 1'b1 && gap < 30) begin
            tick();
            gap++;
        end
        start8 = 1'b0;
        chk("b2b_gap", 32'(gap), 32'd10);
        chk("b2b2_sum",  32'(sum8),  32'h30);
        chk("b2b2_cout", 32'(cout8), 32'd0);
        ticks(2);

        // Degenerate width: half-adder truth table
        for (int k = 0; k < 4; k++) begin
            a1 = w1_a[k][0:0]; b1 = w1_b[k][0:0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("w1_busy", 32'(busy1), 32'd1);
            chk("w1_nodone", 32'(done1), 32'd0);
            tick();
            chk("w1_done", 32'(done1), 32'd1);
            chk("w1_busy_lo", 32'(busy1), 32'd0);
            chk("w1_sum",  32'(sum1),  32'(w1_s[k]));
            chk("w1_cout", 32'(cout1), 32'(w1_c[k]));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
